// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage controller. Consumes the EX/MEM pipeline register,
//               runs data-memory loads/stores over a req/ack handshake with a
//               variable-latency memory (stalling upstream until the access
//               completes), resolves the branch decision for IF and drives
//               the MEM/WB register contents.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ALU_data_in           EX/MEM ALU result (also memory address)
//   rd_data_in            EX/MEM store data
//   branch_target_in      EX/MEM branch target
//   zero_in               EX/MEM zero flag
//   MemtoReg_in .. MemWrite_in, Rd_in   EX/MEM controls / destination reg
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request side
//   mem_rdata/mem_ack     memory response (ack is a one-cycle pulse)
//   mem_stall             hold PC, IF/ID, ID/EX, EX/MEM
//   PCSrc                 branch taken
//   branch_target_out     passthrough of branch_target_in
//   read_data_out, ALU_data_out, MemtoReg_out, regwrite_out, MEM_WB_rd
//                         MEM/WB register contents
//   mem_err               sticky error (timeout or read+write conflict)
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       ALU_data_in,
    input  logic [63:0]       rd_data_in,
    input  logic [7:0]        branch_target_in,
    input  logic              zero_in,
    input  logic              MemtoReg_in,
    input  logic              regwrite_in,
    input  logic              branch_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [4:0]        Rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_stall,
    output logic              PCSrc,
    output logic [7:0]        branch_target_out,
    output logic [63:0]       read_data_out,
    output logic [63:0]       ALU_data_out,
    output logic              MemtoReg_out,
    output logic              regwrite_out,
    output logic [4:0]        MEM_WB_rd,
    output logic              mem_err
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               w_mem_op;
    logic               w_timeout;

    // memory request side
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [63:0]        r_mem_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_err;

    // instruction latched at the IDLE decision, replayed into MEM/WB in DONE
    logic [63:0]        r_lat_alu;
    logic [4:0]         r_lat_rd;
    logic               r_lat_memtoreg;
    logic               r_lat_regwrite;
    logic [63:0]        r_cap_rdata;

    // MEM/WB register
    logic [63:0]        r_wb_rdata;
    logic [63:0]        r_wb_alu;
    logic               r_wb_memtoreg;
    logic               r_wb_regwrite;
    logic [4:0]         r_wb_rd;

    assign w_mem_op  = MemRead_in | MemWrite_in;
    assign w_timeout = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_mem_op) begin
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational outputs. DONE drops the stall so the upstream registers
    // advance on the same edge that retires the memory instruction; this
    // keeps the stalled instruction from being seen twice by IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        mem_stall = 1'b0;
        PCSrc     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                mem_stall = w_mem_op;
                PCSrc     = ~w_mem_op & branch_in & zero_in;
            end
            c_ST_ACCESS: begin
                mem_stall = 1'b1;
            end
            default: begin
                mem_stall = 1'b0;
                PCSrc     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: memory request, latched instruction, MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cnt          <= '0;
            r_mem_err      <= 1'b0;
            r_lat_alu      <= '0;
            r_lat_rd       <= '0;
            r_lat_memtoreg <= 1'b0;
            r_lat_regwrite <= 1'b0;
            r_cap_rdata    <= '0;
            r_wb_rdata     <= '0;
            r_wb_alu       <= '0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mem_op) begin
                        r_lat_alu      <= ALU_data_in;
                        r_lat_rd       <= Rd_in;
                        r_lat_memtoreg <= MemtoReg_in;
                        r_lat_regwrite <= regwrite_in;
                        r_cap_rdata    <= '0;
                        r_mem_addr     <= ALU_data_in[ADDR_W-1:0];
                        r_mem_wdata    <= rd_data_in;
                        // a simultaneous read+write is issued as a write
                        r_mem_we       <= MemWrite_in;
                        r_mem_req      <= 1'b1;
                        r_cnt          <= '0;
                        if (MemRead_in && MemWrite_in) begin
                            r_mem_err <= 1'b1;
                        end
                        r_wb_rdata     <= '0;
                        r_wb_alu       <= '0;
                        r_wb_memtoreg  <= 1'b0;
                        r_wb_regwrite  <= 1'b0;
                        r_wb_rd        <= '0;
                    end else begin
                        r_wb_rdata     <= '0;
                        r_wb_alu       <= ALU_data_in;
                        r_wb_memtoreg  <= MemtoReg_in;
                        r_wb_regwrite  <= regwrite_in;
                        r_wb_rd        <= Rd_in;
                    end
                end
                c_ST_ACCESS: begin
                    r_wb_rdata    <= '0;
                    r_wb_alu      <= '0;
                    r_wb_memtoreg <= 1'b0;
                    r_wb_regwrite <= 1'b0;
                    r_wb_rd       <= '0;
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_cap_rdata <= mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                    end else if (w_timeout) begin
                        // aborted access: retire the instruction harmlessly
                        r_mem_req      <= 1'b0;
                        r_mem_err      <= 1'b1;
                        r_cap_rdata    <= '0;
                        r_lat_regwrite <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_wb_rdata    <= r_cap_rdata;
                    r_wb_alu      <= r_lat_alu;
                    r_wb_memtoreg <= r_lat_memtoreg;
                    r_wb_regwrite <= r_lat_regwrite;
                    r_wb_rd       <= r_lat_rd;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req           = r_mem_req;
    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign mem_err           = r_mem_err;
    assign branch_target_out = branch_target_in;
    assign read_data_out     = r_wb_rdata;
    assign ALU_data_out      = r_wb_alu;
    assign MemtoReg_out      = r_wb_memtoreg;
    assign regwrite_out      = r_wb_regwrite;
    assign MEM_WB_rd         = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed self-checking bench for mem_stage_ctrl. Inputs are
//               driven 1 time unit after the rising edge; outputs are checked
//               mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] ALU_data_in;
    logic [63:0] rd_data_in;
    logic [7:0]  branch_target_in;
    logic        zero_in;
    logic        MemtoReg_in;
    logic        regwrite_in;
    logic        branch_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [4:0]  Rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic        PCSrc;
    logic [7:0]  branch_target_out;
    logic [63:0] read_data_out;
    logic [63:0] ALU_data_out;
    logic        MemtoReg_out;
    logic        regwrite_out;
    logic [4:0]  MEM_WB_rd;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int stall_cnt = 0;
    int req_base;
    int stall_base;

    mem_stage_ctrl #(.ADDR_W(8), .TIMEOUT(16)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .ALU_data_in       (ALU_data_in),
        .rd_data_in        (rd_data_in),
        .branch_target_in  (branch_target_in),
        .zero_in           (zero_in),
        .MemtoReg_in       (MemtoReg_in),
        .regwrite_in       (regwrite_in),
        .branch_in         (branch_in),
        .MemRead_in        (MemRead_in),
        .MemWrite_in       (MemWrite_in),
        .Rd_in             (Rd_in),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .mem_stall         (mem_stall),
        .PCSrc             (PCSrc),
        .branch_target_out (branch_target_out),
        .read_data_out     (read_data_out),
        .ALU_data_out      (ALU_data_out),
        .MemtoReg_out      (MemtoReg_out),
        .regwrite_out      (regwrite_out),
        .MEM_WB_rd         (MEM_WB_rd),
        .mem_err           (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycles with mem_req / mem_stall high, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req)   req_cnt   = req_cnt + 1;
            if (mem_stall) stall_cnt = stall_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [63:0] alu, input logic [63:0] sdata,
                             input logic rd_en, input logic wr_en,
                             input logic m2r, input logic rw, input logic [4:0] rd);
        ALU_data_in = alu;
        rd_data_in  = sdata;
        MemRead_in  = rd_en;
        MemWrite_in = wr_en;
        MemtoReg_in = m2r;
        regwrite_in = rw;
        Rd_in       = rd;
        branch_in   = 1'b0;
        zero_in     = 1'b0;
    endtask

    task automatic mark();
        req_base   = req_cnt;
        stall_base = stall_cnt;
    endtask

    initial begin
        reset            = 1'b1;
        branch_target_in = 8'h00;
        mem_rdata        = '0;
        mem_ack          = 1'b0;
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        // reset state
        check("rst_req",   64'(mem_req), 64'd0);
        check("rst_err",   64'(mem_err), 64'd0);
        check("rst_alu",   ALU_data_out, 64'd0);
        check("rst_rw",    64'(regwrite_out), 64'd0);
        check("rst_stall", 64'(mem_stall), 64'd0);

        // plain ALU op
        set_instr(64'd42, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        #1;
        check("alu_stall0", 64'(mem_stall), 64'd0);
        tick();
        check("alu_data",   ALU_data_out, 64'd42);
        check("alu_rw",     64'(regwrite_out), 64'd1);
        check("alu_rd",     64'(MEM_WB_rd), 64'd5);
        check("alu_stall1", 64'(mem_stall), 64'd0);

        // load, ack in third ACCESS cycle
        mark();
        set_instr(64'h1_0010, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        #1;
        check("ld_stall_idle", 64'(mem_stall), 64'd1);
        tick();
        check("ld_req",    64'(mem_req), 64'd1);
        check("ld_addr",   64'(mem_addr), 64'h10);
        check("ld_we",     64'(mem_we), 64'd0);
        check("ld_bubble", 64'(regwrite_out), 64'd0);
        tick();
        check("ld_req2",   64'(mem_req), 64'd1);
        tick();
        mem_rdata = 64'hDEAD;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        check("ld_done_req",   64'(mem_req), 64'd0);
        check("ld_done_stall", 64'(mem_stall), 64'd0);
        tick();
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("ld_rdata", read_data_out, 64'hDEAD);
        check("ld_m2r",   64'(MemtoReg_out), 64'd1);
        check("ld_rw",    64'(regwrite_out), 64'd1);
        check("ld_rd",    64'(MEM_WB_rd), 64'd7);
        check("ld_alu",   ALU_data_out, 64'h1_0010);
        tick();
        check("ld_req_cycles",   64'(req_cnt - req_base), 64'd3);
        check("ld_stall_cycles", 64'(stall_cnt - stall_base), 64'd4);

        // store, ack on first ACCESS cycle
        mark();
        set_instr(64'd3, 64'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        check("st_we",    64'(mem_we), 64'd1);
        check("st_wdata", mem_wdata, 64'd7);
        check("st_addr",  64'(mem_addr), 64'd3);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("st_rw",    64'(regwrite_out), 64'd0);
        check("st_rdata", read_data_out, 64'd0);
        tick();
        check("st_req_cycles",   64'(req_cnt - req_base), 64'd1);
        check("st_stall_cycles", 64'(stall_cnt - stall_base), 64'd2);
        check("st_err",          64'(mem_err), 64'd0);

        // branch resolution
        branch_in        = 1'b1;
        zero_in          = 1'b1;
        branch_target_in = 8'h24;
        #1;
        check("br_taken",  64'(PCSrc), 64'd1);
        check("br_target", 64'(branch_target_out), 64'h24);
        zero_in = 1'b0;
        #1;
        check("br_nt", 64'(PCSrc), 64'd0);
        zero_in    = 1'b1;
        MemRead_in = 1'b1;
        #1;
        check("br_memop", 64'(PCSrc), 64'd0);
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();

        // timeout: no ack at all
        mark();
        set_instr(64'h20, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
        tick();
        repeat (16) tick();
        check("to_req",  64'(mem_req), 64'd0);
        check("to_err",  64'(mem_err), 64'd1);
        tick();
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("to_rdata", read_data_out, 64'd0);
        check("to_rw",    64'(regwrite_out), 64'd0);
        check("to_rd",    64'(MEM_WB_rd), 64'd9);
        tick();
        check("to_req_cycles",   64'(req_cnt - req_base), 64'd16);
        check("to_stall_cycles", 64'(stall_cnt - stall_base), 64'd17);

        // load after timeout completes normally, error stays set
        set_instr(64'h05, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        mem_rdata = 64'h1234;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        tick();
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("ld2_rdata", read_data_out, 64'h1234);
        check("ld2_rw",    64'(regwrite_out), 64'd1);
        check("ld2_err",   64'(mem_err), 64'd1);

        // reset in the middle of an access
        set_instr(64'h40, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        tick();
        tick();
        check("rsa_req_before", 64'(mem_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_instr(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        check("rsa_req",   64'(mem_req), 64'd0);
        check("rsa_err",   64'(mem_err), 64'd0);
        check("rsa_stall", 64'(mem_stall), 64'd0);
        check("rsa_addr",  64'(mem_addr), 64'd0);
        check("rsa_rw",    64'(regwrite_out), 64'd0);
        mem_rdata = 64'hBEEF;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        check("late_req",   64'(mem_req), 64'd0);
        check("late_rdata", read_data_out, 64'd0);
        check("late_stall", 64'(mem_stall), 64'd0);
        tick();
        check("late_rdata2", read_data_out, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs the data-memory load/store over a req/ack handshake with variable-latency memory, stalling the upstream pipeline until the access completes.
- Resolves the branch decision (PCSrc) for IF.
- Drives the MEM/WB register contents: read data, ALU result, writeback controls, destination register.

Parameters:
ADDR_W, 8, data-memory address width; mem_addr = ALU_data_in[ADDR_W-1:0]
TIMEOUT, 16, maximum ACCESS cycles without mem_ack before the access is aborted

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ALU_data_in  input  64  EX/MEM ALU result; memory address for loads/stores
rd_data_in  input  64  EX/MEM store data
branch_target_in  input  8  EX/MEM branch target
zero_in  input  1  EX/MEM zero flag
MemtoReg_in, regwrite_in, branch_in, MemRead_in, MemWrite_in  input  1 each  EX/MEM controls
Rd_in  input  5  EX/MEM destination register
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  ADDR_W  latched address
mem_wdata  output  64  latched store data
mem_rdata  input  64  read data; valid when mem_ack=1
mem_ack  input  1  one-cycle completion pulse
mem_stall  output  1  combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM
PCSrc  output  1  combinational branch-taken
branch_target_out  output  8  passthrough of branch_target_in
read_data_out  output  64  MEM/WB load data
ALU_data_out  output  64  MEM/WB ALU result
MemtoReg_out, regwrite_out  output  1 each  MEM/WB controls
MEM_WB_rd  output  5  MEM/WB destination register
mem_err  output  1  sticky error flag

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Reset -> IDLE.
- Reset values: all registered outputs 0, mem_err=0.
- Reset mid-ACCESS abandons the transaction; mem_req=0 after that edge.
- mem_op = MemRead_in | MemWrite_in.
- mem_stall = (IDLE & mem_op) | ACCESS. It is 0 in DONE.
- PCSrc = IDLE & !mem_op & branch_in & zero_in.
- IDLE, mem_op=0:
  - Each edge loads MEM/WB: ALU_data_out<=ALU_data_in, MemtoReg/regwrite/Rd from inputs, read_data_out<=0.
  - Latency 1 cycle.
- IDLE, mem_op=1, at the edge:
  - latch Rd, controls, ALU data;
  - mem_addr<=ALU_data_in[ADDR_W-1:0], mem_wdata<=rd_data_in;
  - mem_we<=MemWrite_in; mem_req<=1; clear wait counter;
  - go to ACCESS.
  - MEM/WB receives a bubble (regwrite_out=0, MemtoReg_out=0, MEM_WB_rd=0).
  - MemRead & MemWrite both 1: treated as a write, mem_err<=1.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata held stable. MEM/WB gets a bubble every edge.
  - mem_ack=1 at an edge: capture mem_rdata (reads only), mem_req<=0, go to DONE.
  - Otherwise counter++. If counter==TIMEOUT-1 without ack: mem_req<=0, mem_err<=1, captured data=0, latched regwrite forced 0, go to DONE.
- DONE: at the edge, MEM/WB <= latched controls, ALU data, Rd, and captured read data; go to IDLE. Upstream advances at this same edge.
- Load with ack in the first ACCESS cycle:
  - 3 cycles total: IDLE detect, ACCESS, DONE.
  - MEM/WB valid after the DONE edge.
  - mem_stall high for exactly 2 cycles.
- mem_ack outside ACCESS is ignored.
- mem_err clears only on reset.
- The stalled EX/MEM instruction is never issued twice. DONE consumes it and the IDLE decision sees the next instruction.

Test Plan:
- ALU op: ALU_data_in=42, regwrite=1, Rd=5, no mem -> next edge ALU_data_out=42, regwrite_out=1, MEM_WB_rd=5, mem_stall=0 throughout.
- Load at ALU_data_in=0x1_0010, ack after 3 ACCESS cycles with mem_rdata=0xDEAD -> mem_addr=0x10, mem_we=0, mem_stall high 4 cycles; after DONE edge read_data_out=0xDEAD, MemtoReg_out=1; mem_req high exactly 3 cycles.
- Store rd_data_in=7 at address 3, ack on first ACCESS cycle -> mem_we=1, mem_wdata=7, mem_stall high 2 cycles; MEM/WB regwrite_out=0 except the passed-through store control (0).
- Branch: branch_in=1, zero_in=1, branch_target_in=0x24 -> PCSrc=1 same cycle, branch_target_out=0x24; with zero_in=0 -> PCSrc=0.
- Timeout: load, mem_ack never asserted -> mem_req drops after 16 ACCESS cycles, mem_err=1 sticky, read_data_out=0, regwrite_out=0; a following load completes normally with mem_err still 1.
- Reset asserted during ACCESS -> next edge mem_req=0, state IDLE, all outputs 0, mem_err=0; a late mem_ack is ignored.
